// File: rtl/usb_rx_packet_fifo.sv
// Packet-aware receive byte buffer: bytes commit on clean EOP, roll back on error/overflow; FWFT read.
// Commit visible the cycle after the EOP edge; a full buffer rejects bytes (overflow pulse) and drops the packet.
module usb_rx_packet_fifo #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [7:0]        rx_data,
  input  logic              write_enable,
  input  logic              rcv_error,
  input  logic              eop,
  input  logic              read_enable,
  output logic [7:0]        read_data,
  output logic              data_ready,
  output logic [ADDR_W:0]   committed_count,
  output logic              pkt_done,
  output logic              pkt_dropped,
  output logic              overflow
);

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

  localparam logic [ADDR_W:0] DEPTH_P = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

  logic [7:0]      mem [DEPTH];
  logic [ADDR_W:0] wr_ptr, cm_ptr, rd_ptr;
  state_t          state;
  logic            eop_q, err_q;

  logic eop_rise, err_rise, full, wr_accept, ovf_evt, drop_evt, rd_accept;

  always_comb begin
    eop_rise        = eop & ~eop_q;
    err_rise        = rcv_error & ~err_q;
    full            = (wr_ptr - rd_ptr) == DEPTH_P;
    wr_accept       = write_enable & ~full & (state != DROP) & ~err_rise;
    ovf_evt         = write_enable & full & (state != DROP);
    drop_evt        = (state != DROP) & (err_rise | ovf_evt);
    committed_count = cm_ptr - rd_ptr;
    data_ready      = committed_count != '0;
    rd_accept       = read_enable & data_ready;
    read_data       = mem[rd_ptr[ADDR_W-1:0]];
  end

  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr[ADDR_W-1:0]] <= rx_data;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr      <= '0;
      cm_ptr      <= '0;
      rd_ptr      <= '0;
      state       <= IDLE;
      eop_q       <= 1'b0;
      err_q       <= 1'b0;
      pkt_done    <= 1'b0;
      pkt_dropped <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      eop_q       <= eop;
      err_q       <= rcv_error;
      pkt_done    <= 1'b0;
      pkt_dropped <= 1'b0;
      overflow    <= ovf_evt;
      if (rd_accept) rd_ptr <= rd_ptr + ONE;
      if (wr_accept) wr_ptr <= wr_ptr + ONE;
      case (state)
        IDLE, RECV: begin
          if (drop_evt) begin
            // An error coinciding with EOP has nothing left to wait for: roll back now.
            if (eop_rise) begin
              wr_ptr      <= cm_ptr;
              pkt_dropped <= 1'b1;
              state       <= IDLE;
            end else begin
              state <= DROP;
            end
          end else if (eop_rise && (state == RECV || wr_accept)) begin
            cm_ptr   <= wr_ptr + (ADDR_W+1)'(wr_accept);
            pkt_done <= 1'b1;
            state    <= IDLE;
          end else if (wr_accept) begin
            state <= RECV;
          end
        end
        DROP: begin
          if (eop_rise) begin
            wr_ptr      <= cm_ptr;
            pkt_dropped <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_rx_packet_fifo.sv
// Directed self-checking bench for usb_rx_packet_fifo.
module tb_usb_rx_packet_fifo;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic            clk = 1'b0;
  logic            n_rst;
  logic [7:0]      rx_data;
  logic            write_enable, rcv_error, eop, read_enable;
  logic [7:0]      read_data;
  logic            data_ready;
  logic [ADDR_W:0] committed_count;
  logic            pkt_done, pkt_dropped, overflow;

  int checks = 0;
  int errors = 0;
  int n_done = 0;
  int n_drop = 0;
  int n_ovf  = 0;

  usb_rx_packet_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .n_rst(n_rst), .rx_data(rx_data), .write_enable(write_enable),
    .rcv_error(rcv_error), .eop(eop), .read_enable(read_enable),
    .read_data(read_data), .data_ready(data_ready), .committed_count(committed_count),
    .pkt_done(pkt_done), .pkt_dropped(pkt_dropped), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (pkt_done)    n_done++;
    if (pkt_dropped) n_drop++;
    if (overflow)    n_ovf++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [7:0] b);
    rx_data = b;
    write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
  endtask

  task automatic eop_for(input int n);
    eop = 1'b1;
    repeat (n) tick();
    eop = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    rx_data = 8'h00; write_enable = 1'b0; rcv_error = 1'b0; eop = 1'b0; read_enable = 1'b0;
    #12;
    checks++; if (committed_count !== 7'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", committed_count); end
    checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", data_ready); end
    checks++; if ({pkt_done, pkt_dropped, overflow} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b expected 000", {pkt_done, pkt_dropped, overflow}); end
    @(posedge clk); #1;
    n_rst = 1'b1;
    tick();
  endtask

  task automatic test_clean_packet();
    int d0;
    logic [7:0] exp [3];
    exp[0] = 8'hA5; exp[1] = 8'h3C; exp[2] = 8'h7E;
    d0 = n_done;
    for (int i = 0; i < 3; i++) wr_byte(exp[i]);
    checks++; if (committed_count !== 7'd0) begin errors++; $display("FAIL clean_precommit: got %0d expected 0", committed_count); end
    eop_for(3);
    tick();
    checks++; if (n_done - d0 !== 1) begin errors++; $display("FAIL clean_done_pulses: got %0d expected 1", n_done - d0); end
    checks++; if (committed_count !== 7'd3) begin errors++; $display("FAIL clean_count: got %0d expected 3", committed_count); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (read_data !== exp[i]) begin errors++; $display("FAIL clean_read%0d: got %h expected %h", i, read_data, exp[i]); end
      read_enable = 1'b1; tick(); read_enable = 1'b0;
    end
    checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL clean_drained: got %b expected 0", data_ready); end
  endtask

  task automatic test_error_rollback();
    int dd, dp;
    dd = n_done; dp = n_drop;
    wr_byte(8'h11);
    eop_for(1); tick();
    wr_byte(8'h22);
    wr_byte(8'h33);
    rcv_error = 1'b1; tick(); rcv_error = 1'b0;
    eop_for(1); tick(); tick();
    checks++; if (n_drop - dp !== 1) begin errors++; $display("FAIL err_dropped: got %0d expected 1", n_drop - dp); end
    checks++; if (n_done - dd !== 1) begin errors++; $display("FAIL err_done: got %0d expected 1", n_done - dd); end
    checks++; if (committed_count !== 7'd1) begin errors++; $display("FAIL err_count: got %0d expected 1", committed_count); end
    checks++; if (read_data !== 8'h11) begin errors++; $display("FAIL err_read: got %h expected 11", read_data); end
    read_enable = 1'b1; tick(); read_enable = 1'b0;
    checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL err_drained: got %b expected 0", data_ready); end
  endtask

  task automatic test_overflow();
    int d0, dp;
    d0 = n_ovf; dp = n_drop;
    for (int i = 0; i < 64; i++) wr_byte(8'(i));
    tick();
    checks++; if (n_ovf - d0 !== 0) begin errors++; $display("FAIL ovf_early: got %0d expected 0", n_ovf - d0); end
    wr_byte(8'hEE);
    tick();
    checks++; if (n_ovf - d0 !== 1) begin errors++; $display("FAIL ovf_byte65: got %0d expected 1", n_ovf - d0); end
    wr_byte(8'hEF);
    wr_byte(8'hF0);
    tick();
    checks++; if (n_ovf - d0 !== 1) begin errors++; $display("FAIL ovf_in_drop: got %0d expected 1", n_ovf - d0); end
    eop_for(1); tick(); tick();
    checks++; if (n_drop - dp !== 1) begin errors++; $display("FAIL ovf_dropped: got %0d expected 1", n_drop - dp); end
    checks++; if (committed_count !== 7'd0) begin errors++; $display("FAIL ovf_count: got %0d expected 0", committed_count); end
    checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready: got %b expected 0", data_ready); end
  endtask

  task automatic test_wrap();
    int d0;
    logic [7:0] v, e;
    d0 = n_done;
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 40; i++) begin
        v = 8'(p * 40 + i) ^ 8'h5A;
        rx_data = v; write_enable = 1'b1;
        read_enable = (p > 0);
        if (p > 0) begin
          e = 8'((p - 1) * 40 + i) ^ 8'h5A;
          checks++; if (read_data !== e) begin errors++; $display("FAIL wrap_read p%0d i%0d: got %h expected %h", p, i, read_data, e); end
        end
        tick();
      end
      write_enable = 1'b0; read_enable = 1'b0;
      eop_for(1);
      checks++; if (committed_count !== 7'd40) begin errors++; $display("FAIL wrap_count p%0d: got %0d expected 40", p, committed_count); end
    end
    for (int i = 0; i < 40; i++) begin
      e = 8'(3 * 40 + i) ^ 8'h5A;
      checks++; if (read_data !== e) begin errors++; $display("FAIL wrap_drain i%0d: got %h expected %h", i, read_data, e); end
      read_enable = 1'b1; tick(); read_enable = 1'b0;
    end
    checks++; if (committed_count !== 7'd0) begin errors++; $display("FAIL wrap_final_count: got %0d expected 0", committed_count); end
    checks++; if (n_done - d0 !== 4) begin errors++; $display("FAIL wrap_done: got %0d expected 4", n_done - d0); end
  endtask

  task automatic test_simultaneous();
    int dd, dp;
    // Byte written alongside the EOP edge is part of the commit.
    wr_byte(8'h01);
    rx_data = 8'h02; write_enable = 1'b1; eop = 1'b1;
    tick();
    write_enable = 1'b0; eop = 1'b0;
    checks++; if (committed_count !== 7'd2) begin errors++; $display("FAIL sim_eop_write_count: got %0d expected 2", committed_count); end
    checks++; if (read_data !== 8'h01) begin errors++; $display("FAIL sim_eop_read0: got %h expected 01", read_data); end
    read_enable = 1'b1; tick(); read_enable = 1'b0;
    checks++; if (read_data !== 8'h02) begin errors++; $display("FAIL sim_eop_read1: got %h expected 02", read_data); end
    read_enable = 1'b1; tick(); read_enable = 1'b0;
    // Zero-length packet produces no pulses.
    tick();
    dd = n_done; dp = n_drop;
    eop_for(1); tick(); tick();
    checks++; if ((n_done - dd) + (n_drop - dp) !== 0) begin errors++; $display("FAIL sim_zero_len: got %0d pulses expected 0", (n_done - dd) + (n_drop - dp)); end
    // Read on empty leaves the pointers alone.
    read_enable = 1'b1; tick(); tick(); read_enable = 1'b0;
    checks++; if ({data_ready, committed_count} !== 8'd0) begin errors++; $display("FAIL sim_empty_read: got ready=%b count=%0d expected 0/0", data_ready, committed_count); end
    wr_byte(8'h55);
    eop_for(1);
    checks++; if (committed_count !== 7'd1 || read_data !== 8'h55) begin errors++; $display("FAIL sim_after_empty: got count=%0d data=%h expected 1/55", committed_count, read_data); end
    read_enable = 1'b1; tick(); read_enable = 1'b0;
    // Error arriving with a write drops that byte and the packet.
    dp = n_drop;
    wr_byte(8'h10);
    rx_data = 8'h20; write_enable = 1'b1; rcv_error = 1'b1;
    tick();
    write_enable = 1'b0; rcv_error = 1'b0;
    eop_for(1); tick(); tick();
    checks++; if (n_drop - dp !== 1) begin errors++; $display("FAIL sim_err_write_drop: got %0d expected 1", n_drop - dp); end
    checks++; if (committed_count !== 7'd0) begin errors++; $display("FAIL sim_err_write_count: got %0d expected 0", committed_count); end
    wr_byte(8'h30);
    eop_for(1);
    checks++; if (committed_count !== 7'd1 || read_data !== 8'h30) begin errors++; $display("FAIL sim_err_next_pkt: got count=%0d data=%h expected 1/30", committed_count, read_data); end
    read_enable = 1'b1; tick(); read_enable = 1'b0;
  endtask

  task automatic test_reset_mid_packet();
    tick();
    for (int i = 1; i <= 5; i++) wr_byte(8'(i));
    eop_for(1); tick();
    wr_byte(8'h06);
    wr_byte(8'h07);
    checks++; if (committed_count !== 7'd5) begin errors++; $display("FAIL rst_pre_count: got %0d expected 5", committed_count); end
    #2;
    n_rst = 1'b0;
    #1;
    checks++; if (committed_count !== 7'd0 || data_ready !== 1'b0) begin errors++; $display("FAIL rst_async_state: got count=%0d ready=%b expected 0/0", committed_count, data_ready); end
    checks++; if ({pkt_done, pkt_dropped, overflow} !== 3'b000) begin errors++; $display("FAIL rst_async_pulses: got %b expected 000", {pkt_done, pkt_dropped, overflow}); end
    @(posedge clk); #1;
    n_rst = 1'b1;
    tick();
    wr_byte(8'h99);
    eop_for(1);
    checks++; if (committed_count !== 7'd1) begin errors++; $display("FAIL rst_after_count: got %0d expected 1", committed_count); end
    checks++; if (read_data !== 8'h99) begin errors++; $display("FAIL rst_after_data: got %h expected 99", read_data); end
    read_enable = 1'b1; tick(); read_enable = 1'b0;
    checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL rst_after_drained: got %b expected 0", data_ready); end
  endtask

  initial begin
    test_reset();
    test_clean_packet();
    test_error_rollback();
    test_overflow();
    test_wrap();
    test_simultaneous();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
